// File: rtl/score_keeper_if.sv
// Snake score keeper bus: game events in, score/state out.
// Master drives the game events; slave drives score and state.
interface score_keeper_if #(
  parameter int WIDTH = 4
);
  logic             eat;
  logic             game_over;
  logic             restart;
  logic [WIDTH-1:0] score;
  logic [7:0]       score_bcd;
  logic [WIDTH-1:0] high_score;
  logic             win;
  logic             over;
  logic             score_upd;

  modport master (
    output eat,
    output game_over,
    output restart,
    input  score,
    input  score_bcd,
    input  high_score,
    input  win,
    input  over,
    input  score_upd
  );

  modport slave (
    input  eat,
    input  game_over,
    input  restart,
    output score,
    output score_bcd,
    output high_score,
    output win,
    output over,
    output score_upd
  );
endinterface

// File: rtl/score_keeper.sv
// Snake score keeper: saturating score, game state, high score,
// with registered binary and packed-BCD outputs.
module score_keeper #(
  parameter int WIDTH     = 4,
  parameter int MAX_SCORE = 13
) (
  input  logic clk,
  input  logic rst,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MAX_SCORE);
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             eat_q, restart_q;
  logic [WIDTH-1:0] score_q, score_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [7:0]       bcd_q, bcd_d;
  logic             win_q, win_d;
  logic             over_q, over_d;
  logic             upd_q, upd_d;
  logic             eat_rise, restart_rise;
  logic [7:0]       s8;

  assign eat_rise     = bus.eat & ~eat_q;
  assign restart_rise = bus.restart & ~restart_q;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    unique case (state_q)
      PLAY: begin
        // collision outranks a same-cycle eat
        if (bus.game_over) begin
          state_d = OVER;
          if (score_q > high_q) high_d = score_q;
        end else if (eat_rise && score_q < MAX) begin
          score_d = score_q + ONE;
          if (score_d == MAX) begin
            state_d = WON;
            if (MAX > high_q) high_d = MAX;
          end
        end
      end
      WON, OVER: begin
        if (restart_rise) begin
          state_d = PLAY;
          score_d = '0;
        end
      end
      default: state_d = PLAY;
    endcase
    s8     = 8'(score_d);
    bcd_d  = {4'(s8 / 8'd10), 4'(s8 % 8'd10)};
    win_d  = (state_d == WON);
    over_d = (state_d == OVER);
    upd_d  = (score_d != score_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLAY;
      eat_q     <= 1'b0;
      restart_q <= 1'b0;
      score_q   <= '0;
      high_q    <= '0;
      bcd_q     <= 8'h00;
      win_q     <= 1'b0;
      over_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      eat_q     <= bus.eat;
      restart_q <= bus.restart;
      score_q   <= score_d;
      high_q    <= high_d;
      bcd_q     <= bcd_d;
      win_q     <= win_d;
      over_q    <= over_d;
      upd_q     <= upd_d;
    end
  end

  assign bus.score      = score_q;
  assign bus.score_bcd  = bcd_q;
  assign bus.high_score = high_q;
  assign bus.win        = win_q;
  assign bus.over       = over_q;
  assign bus.score_upd  = upd_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table, directed corner
// sequences and random stimulus against a game-rule model.
module tb_score_keeper;

  localparam int W  = 4;
  localparam int MX = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if #(.WIDTH(W)) bus ();

  score_keeper #(
    .WIDTH    (W),
    .MAX_SCORE(MX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_run  = 0;
  int n_fail = 0;

  // game-rule model
  int m_score, m_high, m_mode; // mode 0 play, 1 won, 2 over
  bit m_pe, m_pr, m_upd;
  bit use_model = 1'b0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 10) * 16) + (v % 10);
  endfunction

  task automatic model_step(input bit r, e, g, s);
    int old;
    bit er, sr;
    if (r) begin
      m_score = 0; m_high = 0; m_mode = 0;
      m_pe = 0; m_pr = 0; m_upd = 0;
      return;
    end
    er  = e && !m_pe;
    sr  = s && !m_pr;
    old = m_score;
    if (m_mode == 0) begin
      if (g) begin
        m_mode = 2;
        if (m_score > m_high) m_high = m_score;
      end else if (er && m_score < MX) begin
        m_score = m_score + 1;
        if (m_score == MX) begin
          m_mode = 1;
          if (MX > m_high) m_high = MX;
        end
      end
    end else if (sr) begin
      m_mode  = 0;
      m_score = 0;
    end
    m_upd = (m_score != old);
    m_pe  = e;
    m_pr  = s;
  endtask

  task automatic cmp_model();
    chk("score", int'(bus.score), m_score);
    chk("bcd", int'(bus.score_bcd), to_bcd(m_score));
    chk("high", int'(bus.high_score), m_high);
    chk("win", int'(bus.win), int'(m_mode == 1));
    chk("over", int'(bus.over), int'(m_mode == 2));
    chk("upd", int'(bus.score_upd), int'(m_upd));
  endtask

  task automatic cyc(input bit r, e, g, s);
    rst           = r;
    bus.eat       = e;
    bus.game_over = g;
    bus.restart   = s;
    @(posedge clk);
    #1;
    model_step(r, e, g, s);
    if (use_model) cmp_model();
  endtask

  task automatic pulses(input int n, output int ups);
    ups = 0;
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0);
      ups += int'(bus.score_upd);
      cyc(0, 0, 0, 0);
      ups += int'(bus.score_upd);
    end
  endtask

  typedef struct {
    bit r, e, g, s;
    int score, bcd, high;
    bit win, over, upd;
  } vec_t;

  vec_t vt[15];

  initial begin
    int ups, base;
    bus.eat = 0; bus.game_over = 0; bus.restart = 0;

    vt[0]  = '{1,0,0,0, 0,'h00,0, 0,0,0};
    vt[1]  = '{0,1,0,0, 1,'h01,0, 0,0,1};
    vt[2]  = '{0,0,0,0, 1,'h01,0, 0,0,0};
    vt[3]  = '{0,1,0,0, 2,'h02,0, 0,0,1};
    vt[4]  = '{0,1,0,0, 2,'h02,0, 0,0,0};
    vt[5]  = '{0,0,0,0, 2,'h02,0, 0,0,0};
    vt[6]  = '{0,1,1,0, 2,'h02,2, 0,1,0};
    vt[7]  = '{0,0,0,0, 2,'h02,2, 0,1,0};
    vt[8]  = '{0,0,0,1, 0,'h00,2, 0,0,1};
    vt[9]  = '{0,1,0,1, 1,'h01,2, 0,0,1};
    vt[10] = '{0,0,0,0, 1,'h01,2, 0,0,0};
    vt[11] = '{0,0,1,0, 1,'h01,2, 0,1,0};
    vt[12] = '{0,1,0,1, 0,'h00,2, 0,0,1};
    vt[13] = '{1,1,1,1, 0,'h00,0, 0,0,0};
    vt[14] = '{0,1,0,0, 1,'h01,0, 0,0,1};

    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].r, vt[i].e, vt[i].g, vt[i].s);
      chk($sformatf("vec%0d.score", i),
          int'(bus.score), vt[i].score);
      chk($sformatf("vec%0d.bcd", i),
          int'(bus.score_bcd), vt[i].bcd);
      chk($sformatf("vec%0d.high", i),
          int'(bus.high_score), vt[i].high);
      chk($sformatf("vec%0d.win", i),
          int'(bus.win), int'(vt[i].win));
      chk($sformatf("vec%0d.over", i),
          int'(bus.over), int'(vt[i].over));
      chk($sformatf("vec%0d.upd", i),
          int'(bus.score_upd), int'(vt[i].upd));
    end

    use_model = 1'b1;

    // five eats, then saturation at the win threshold
    cyc(1, 0, 0, 0);
    pulses(5, ups);
    chk("five.score", int'(bus.score), 5);
    chk("five.bcd", int'(bus.score_bcd), 'h05);
    chk("five.upds", ups, 5);
    pulses(8, ups);
    chk("win.score", int'(bus.score), 13);
    chk("win.bcd", int'(bus.score_bcd), 'h13);
    chk("win.flag", int'(bus.win), 1);
    chk("win.high", int'(bus.high_score), 13);
    pulses(1, ups);
    chk("sat.score", int'(bus.score), 13);
    chk("sat.upds", ups, 0);

    // game over with a same-cycle eat, then restart
    cyc(1, 0, 0, 0);
    pulses(7, ups);
    cyc(0, 1, 1, 0);
    chk("go.over", int'(bus.over), 1);
    chk("go.score", int'(bus.score), 7);
    chk("go.high", int'(bus.high_score), 7);
    chk("go.upd", int'(bus.score_upd), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("rs.score", int'(bus.score), 0);
    chk("rs.upd", int'(bus.score_upd), 1);
    chk("rs.over", int'(bus.over), 0);
    cyc(0, 0, 0, 0);
    chk("rs.upd2", int'(bus.score_upd), 0);
    pulses(3, ups);
    cyc(0, 0, 1, 0);
    chk("low.high", int'(bus.high_score), 7);
    chk("low.score", int'(bus.score), 3);

    // restart from score 0 is silent
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("rs0.upd", int'(bus.score_upd), 0);
    cyc(0, 0, 0, 0);

    // eat held high counts once
    base = int'(bus.score);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("held.delta", int'(bus.score) - base, 1);

    // mid-game reset clears high score too
    cyc(1, 0, 0, 0);
    pulses(12, ups);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    pulses(9, ups);
    chk("pre.score", int'(bus.score), 9);
    chk("pre.high", int'(bus.high_score), 12);
    cyc(1, 1, 1, 1);
    chk("rst.score", int'(bus.score), 0);
    chk("rst.bcd", int'(bus.score_bcd), 0);
    chk("rst.high", int'(bus.high_score), 0);
    chk("rst.win", int'(bus.win), 0);
    chk("rst.over", int'(bus.over), 0);
    chk("rst.upd", int'(bus.score_upd), 0);

    // random play
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(63) == 0,
          $urandom_range(1) == 1,
          $urandom_range(47) == 0,
          $urandom_range(7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game score register for Gluttonous Snake: the producer of the score value consumed by the seven-segment display driver. It counts food-eaten events and saturates at a win threshold. It tracks game state (playing / won / over) and holds a session high score. All outputs are registered and presented in binary and packed BCD, so the display side needs no conversion.

## Interface
Parameters:
- WIDTH, 4, bit width of `score` and `high_score`.
- MAX_SCORE, 13, win threshold. Legal range is 1..min(2**WIDTH-1, 99).

Ports:
- clk  input  1  system clock. Single clock domain.
- rst  input  1  synchronous, active-high reset.
- eat  input  1  food-eaten indication from game logic. Level or pulse; only its rising edge counts.
- game_over  input  1  collision indication. Level; sampled every cycle.
- restart  input  1  start a new game. Level; only its rising edge counts.
- score  output  WIDTH  current score, binary.
- score_bcd  output  8  current score as packed BCD: [7:4] tens, [3:0] units.
- high_score  output  WIDTH  best final score since reset.
- win  output  1  high while in state WON.
- over  output  1  high while in state OVER.
- score_upd  output  1  one-cycle pulse after any change of `score`.

## Operation
- Edge detection:
  - Registers eat_q and restart_q hold the previous samples.
  - eat_rise = eat & ~eat_q; restart_rise = restart & ~restart_q.
  - Both registers clear to 0 on rst. An input already high when rst deasserts therefore counts as a rising edge on the first active cycle.
- States: PLAY, WON, OVER. On reset the state is PLAY.
- PLAY:
  - game_over=1: go to OVER; score holds. game_over takes priority over eat_rise in the same cycle, and that eat is dropped.
  - Otherwise, eat_rise: score <= score+1. If score+1 == MAX_SCORE, go to WON on the same edge.
  - restart_rise is ignored.
- WON / OVER:
  - eat_rise and game_over are ignored.
  - restart_rise: go to PLAY and set score <= 0.
- High score:
  - On the edge that enters WON or OVER: high_score <= max(high_score, final score). For WON the final score is MAX_SCORE.
  - high_score is never cleared except by rst.
- Score never exceeds MAX_SCORE and never wraps.
- score_bcd is computed from the next score value and registered on the same edge as score, so the two always agree.
- score_upd is registered: 1 for exactly the cycle following any edge on which score changed value.
  - Restart from score 0 produces no pulse.
  - Restart from a nonzero score produces one pulse.
- win = (state==WON) and over = (state==OVER), both registered.

## Timing
- Reset values: score=0, score_bcd=8'h00, high_score=0, win=0, over=0, score_upd=0, state=PLAY.
- Latency: eat_rise sampled at edge k → score, score_bcd, win (if the threshold is reached) and high_score (if entering WON) are valid after edge k. score_upd is high for cycle k..k+1 only.
- game_over sampled at edge k → over=1 and high_score updated after edge k.
- Back-to-back eat pulses (high 1 cycle, low 1 cycle) each count. Eat held high for N cycles counts once.
- rst asserted mid-game returns every register to its reset value at that edge, regardless of the other inputs. high_score is lost.
- Simultaneous restart_rise and eat_rise in WON/OVER: restart wins, score=0, and the eat is not counted.
- Simultaneous game_over and the eat that would reach MAX_SCORE: go to OVER with score unchanged and win=0.

## Test plan
- Reset, then 5 eat pulses → score=5, score_bcd=8'h05, five score_upd pulses, win=0, over=0.
- 13 eat pulses → after the 13th edge: score=13, score_bcd=8'h13, win=1, high_score=13. A 14th eat leaves score=13 with no score_upd.
- Score 7, then game_over=1 together with an eat pulse → over=1, score=7, high_score=7, no score_upd.
- From OVER with score 7 and high_score 7: restart pulse → state PLAY, score=0, one score_upd pulse. Then 3 eats and game_over → high_score stays 7.
- eat held high for 10 cycles → score increments by exactly 1.
- rst asserted for one cycle at score 9 with high_score 12 → all outputs 0 on the next cycle, including high_score.
